sd_sector_buffer: RTL
=====================

Name: sd_sector_buffer

Overview:
- Double-buffered 512-byte sector assembler, directly upstream of the SPI SD-card master's block-write path.
- Accepts a byte stream from the logging datapath with a valid/ready handshake and packs it into two BRAM banks.
- Raises a block-write request with an auto-incrementing sector address per full bank; the SD master then pulls the bytes out.
- Lets logging continue into one bank while the other is being written to the card.

Parameters:
- SECTOR_BYTES, 512, bytes per bank; power of two.
- MAX_RETRY, 3, re-requests of a sector after blk_err before it is dropped.
- ADDR_W, 32, sector address width.

Ports:
- clk_peri  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  buffer can accept; a byte transfers when in_valid&in_ready.
- sect_load  in  1  one-cycle pulse; loads the sector counter.
- sect_start  in  ADDR_W  value loaded by sect_load.
- flush  in  1  one-cycle pulse; closes the partial bank (see Optional Feature).
- blk_req  out  1  bank ready for the SD master.
- blk_addr  out  ADDR_W  sector address for the pending bank; stable while blk_req or transfer is active.
- blk_ack  in  1  master accepted the request.
- blk_rd_en  in  1  master reads the next byte.
- blk_rd_data  out  8  byte; valid the cycle after blk_rd_en.
- blk_done  in  1  one-cycle pulse; sector write finished.
- blk_err  in  1  qualifies blk_done; 1 = write failed.
- err_drop  out  1  sticky; a sector was dropped after retries. Cleared by reset or sect_load.
- banks_full  out  2  per-bank full flags, for status.

Behaviour:
- Reset values:
  - in_ready=1, blk_req=0, blk_addr=0, blk_rd_data=0, err_drop=0, banks_full=0.
  - Sector counter=0, write bank=0, write pointer=0.
- Write side:
  - On each accepted byte, store it at bank wr_bank, offset wptr; wptr++.
  - When the byte at offset SECTOR_BYTES-1 is accepted:
    - Set full[wr_bank] and assign that bank the current sector counter value.
    - Increment the counter (modulo 2^ADDR_W).
    - wr_bank toggles and wptr=0.
  - in_ready = !full[wr_bank], registered-equivalent: after the 2nd bank fills, in_ready drops in the following cycle and no byte is lost.
- Read FSM states IDLE, REQ, XFER, WAIT.
  - IDLE:
    - If a bank is full, select the oldest (rd_bank), load blk_addr, rptr=0, go to REQ.
    - The bank fill order is strictly alternating, so oldest = rd_bank pointer.
  - REQ:
    - blk_req=1.
    - On blk_ack, go to XFER; blk_req falls in the same cycle the state changes.
  - XFER:
    - Each blk_rd_en reads offset rptr and increments rptr; data appears next cycle.
    - blk_rd_en with rptr==SECTOR_BYTES is ignored; blk_rd_data holds 0x00.
    - blk_done is accepted in XFER or WAIT; WAIT is entered once rptr==SECTOR_BYTES.
  - On blk_done with blk_err=0:
    - Clear full[rd_bank], toggle rd_bank, retry count=0, go to IDLE.
  - On blk_done with blk_err=1:
    - If retries<MAX_RETRY: retries++, rptr=0, go to REQ with the same blk_addr.
    - Otherwise: set err_drop, free the bank as on success, go to IDLE.
  - Earliest next request: blk_req for the next bank asserts 2 cycles after blk_done, via IDLE.
- sect_load:
  - Overwrites the sector counter.
  - Already-full banks keep their assigned addresses; the load affects only the next bank to fill.
  - Also clears err_drop.
- Simultaneous events:
  - A byte completing a bank in the same cycle blk_done frees the other bank: both flags update and in_ready stays 1.
  - sect_load in the same cycle a bank fills: the filling bank gets the old counter value; the counter takes sect_start (the increment is discarded).
- Reset mid-transfer:
  - All state is cleared and buffered data is discarded.
  - blk_req=0 in the next cycle; the SD master must be reset together with this block.

Optional Feature:
- Macro: SD_SECTOR_BUFFER_FLUSH_EN.
- Defined:
  - flush with wptr>0 pads the rest of the current bank with 0x00 at one byte per cycle.
  - in_ready=0 while padding; the bank is then marked full exactly as a normal fill.
  - flush with wptr==0 does nothing.
  - flush during padding is ignored.
- Not defined: the flush input is ignored and partial banks are only written when they fill.

Test Plan:
- Reset, sect_load start=0x100, stream 512 bytes 0x00..0xFF twice -> blk_req=1, blk_addr=0x100. Master acks and reads 512 bytes matching the input, then blk_done -> bank freed, in_ready stays 1 throughout.
- Stream 1024 bytes with no master ack -> banks_full=2'b11, in_ready=0 from the cycle after byte 1024. Byte 1025 is held until blk_done, then accepted into bank 0. The 2nd request shows blk_addr=0x101.
- blk_done with blk_err=1 three times on sector 0x200 (MAX_RETRY=3) -> three re-requests at 0x200 with data unchanged. The 4th failure sets err_drop=1 and the next request shows 0x201.
- blk_rd_en held for 520 cycles in XFER -> bytes 0..511 correct, reads 513..520 return 0x00, rptr does not wrap.
- With SD_SECTOR_BUFFER_FLUSH_EN: 10 bytes 0xAA then flush -> in_ready=0 for 502 cycles. Master reads 10×0xAA then 502×0x00. Without the macro: no blk_req.
- Assert reset during XFER at byte 100 -> next cycle blk_req=0, banks_full=0, in_ready=1, err_drop=0.

Source files
------------

// File: rtl/sd_sector_buffer.sv
// Purpose : double-buffered sector assembler feeding the SD-card master's block-write path.
// Latency : a filled bank raises blk_req 2 cycles after its last byte; blk_rd_data is valid 1 cycle after blk_rd_en.
// Backpr. : in_ready drops the cycle after both banks are full (or while padding); no byte is ever dropped.
//
// Ports:
//   clk_peri, reset                   clock and synchronous active-high reset
//   in_data/in_valid/in_ready         logging byte stream (valid/ready)
//   sect_load/sect_start              load the sector counter (also clears err_drop)
//   flush                             close a partial bank (only with SD_SECTOR_BUFFER_FLUSH_EN)
//   blk_req/blk_addr/blk_ack          block-write request handshake to the SD master
//   blk_rd_en/blk_rd_data             byte pull interface, one-cycle read latency
//   blk_done/blk_err                  end-of-sector status from the SD master
//   err_drop, banks_full              sticky drop flag and per-bank full status
//
// Optional feature macro: SD_SECTOR_BUFFER_FLUSH_EN (zero-pads and closes a partial bank on flush).

module sd_sector_buffer #(
    parameter int SECTOR_BYTES = 512,
    parameter int MAX_RETRY    = 3,
    parameter int ADDR_W       = 32
) (
    input  logic              clk_peri,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sect_load,
    input  logic [ADDR_W-1:0] sect_start,
    input  logic              flush,
    output logic              blk_req,
    output logic [ADDR_W-1:0] blk_addr,
    input  logic              blk_ack,
    input  logic              blk_rd_en,
    output logic [7:0]        blk_rd_data,
    input  logic              blk_done,
    input  logic              blk_err,
    output logic              err_drop,
    output logic [1:0]        banks_full
);

    localparam int PTR_W   = $clog2(SECTOR_BYTES);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_WAIT
    } rd_state_t;

    // ------------------------------------------------------------------
    // Storage: both banks live in one memory, bank index is the address MSB.
    // ------------------------------------------------------------------
    logic [7:0]        mem [2*SECTOR_BYTES];

    // Write side state
    logic              wr_bank;
    logic [PTR_W-1:0]  wptr;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic [ADDR_W-1:0] bank_addr [2];
    logic [ADDR_W-1:0] sect_cnt;

    // Read side state
    rd_state_t         state;
    rd_state_t         state_nxt;
    logic              rd_bank;
    logic [PTR_W:0]    rptr;        // one extra bit so "all bytes read" is representable
    logic [RETRY_W-1:0] retry_cnt;
    logic [7:0]        rd_q;
    logic              rd_zero;

    // Strobes decoded by the read FSM
    logic              ld_req;
    logic              rd_fire;
    logic              rd_null;
    logic              free_bank;
    logic              do_retry;
    logic              set_drop;

    // Write-path strobes
    logic              pad_active;
    logic              wr_fire;
    logic              wr_en;
    logic [7:0]        wr_byte;
    logic              wr_last;

    // ------------------------------------------------------------------
    // Optional flush: zero-pad the current bank one byte per cycle.
    // ------------------------------------------------------------------
`ifdef SD_SECTOR_BUFFER_FLUSH_EN
    logic pad_q;

    // The completing write wins over a coincident flush so an already
    // closing bank is never padded a second time from offset 0.
    always_ff @(posedge clk_peri) begin
        if (reset) begin
            pad_q <= 1'b0;
        end else if (wr_last) begin
            pad_q <= 1'b0;
        end else if (flush && (wptr != '0)) begin
            pad_q <= 1'b1;
        end
    end

    assign pad_active = pad_q;
`else
    logic unused_flush;

    assign pad_active   = 1'b0;
    assign unused_flush = flush;
`endif

    // in_ready is a pure function of registered state, so it falls the cycle
    // after the second bank fills and the write in that cycle is still legal.
    assign in_ready = !full[wr_bank] && !pad_active;
    assign wr_fire  = in_valid && in_ready;
    assign wr_en    = wr_fire || pad_active;
    assign wr_byte  = pad_active ? 8'h00 : in_data;
    assign wr_last  = wr_en && (wptr == '1);

    // A fill and a free can land in the same cycle; they always target
    // different banks because a full bank is never being written.
    always_comb begin
        full_nxt = full;
        if (wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (free_bank) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk_peri) begin
        if (reset) begin
            wr_bank      <= 1'b0;
            wptr         <= '0;
            full         <= '0;
            sect_cnt     <= '0;
            err_drop     <= 1'b0;
            bank_addr[0] <= '0;
            bank_addr[1] <= '0;
        end else begin
            full <= full_nxt;

            if (wr_en) begin
                wptr <= wptr + 1'b1;    // wraps to 0 on the last byte (power-of-two bank)
            end
            if (wr_last) begin
                bank_addr[wr_bank] <= sect_cnt;
                wr_bank            <= ~wr_bank;
            end

            // A load coinciding with a fill: the filling bank already took the
            // old value above, and the increment is discarded here.
            if (sect_load) begin
                sect_cnt <= sect_start;
            end else if (wr_last) begin
                sect_cnt <= sect_cnt + 1'b1;
            end

            // A drop in the same cycle as a load is kept visible rather than lost.
            if (set_drop) begin
                err_drop <= 1'b1;
            end else if (sect_load) begin
                err_drop <= 1'b0;
            end
        end
    end

    // Memory write and registered read kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk_peri) begin
        if (wr_en) begin
            mem[{wr_bank, wptr}] <= wr_byte;
        end
        if (rd_fire) begin
            rd_q <= mem[{rd_bank, rptr[PTR_W-1:0]}];
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_peri) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        blk_req   = 1'b0;
        ld_req    = 1'b0;
        rd_fire   = 1'b0;
        rd_null   = 1'b0;
        free_bank = 1'b0;
        do_retry  = 1'b0;
        set_drop  = 1'b0;

        case (state)
            ST_IDLE: begin
                // Banks fill strictly alternately, so rd_bank is always the oldest.
                if (full[rd_bank]) begin
                    ld_req    = 1'b1;
                    state_nxt = ST_REQ;
                end
            end

            ST_REQ: begin
                blk_req = 1'b1;
                if (blk_ack) begin
                    state_nxt = ST_XFER;
                end
            end

            ST_XFER, ST_WAIT: begin
                if (blk_rd_en) begin
                    if (rptr[PTR_W]) begin
                        rd_null = 1'b1;
                    end else begin
                        rd_fire = 1'b1;
                    end
                end

                if (blk_done) begin
                    if (blk_err && (retry_cnt < RETRY_W'(MAX_RETRY))) begin
                        do_retry  = 1'b1;
                        state_nxt = ST_REQ;
                    end else begin
                        free_bank = 1'b1;
                        set_drop  = blk_err;
                        state_nxt = ST_IDLE;
                    end
                end else if (rptr[PTR_W]) begin
                    state_nxt = ST_WAIT;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_peri) begin
        if (reset) begin
            rd_bank   <= 1'b0;
            rptr      <= '0;
            retry_cnt <= '0;
            blk_addr  <= '0;
            rd_zero   <= 1'b1;
        end else begin
            if (ld_req) begin
                blk_addr <= bank_addr[rd_bank];
                rptr     <= '0;
            end

            if (rd_fire) begin
                rptr    <= rptr + 1'b1;
                rd_zero <= 1'b0;
            end else if (rd_null) begin
                rd_zero <= 1'b1;
            end

            // A retry restarts the same sector from byte 0; blk_addr is untouched.
            if (do_retry) begin
                retry_cnt <= retry_cnt + 1'b1;
                rptr      <= '0;
            end

            if (free_bank) begin
                rd_bank   <= ~rd_bank;
                retry_cnt <= '0;
            end
        end
    end

    // Reads past the end of the sector (and the reset state) present 0x00
    // without disturbing the RAM output register.
    assign blk_rd_data = rd_zero ? 8'h00 : rd_q;
    assign banks_full  = full;

endmodule
